fb_write_arbiter: RTL and testbench

Owns the write port of the dual-port framebuffer SRAM and shares it between two requesters: the pixel renderer (valid/ready stream) and a built-in clear engine that fills every location with one colour. Sits between the renderer and the sram write inputs (i_write, i_write_addr, i_data). The VGA scanout keeps exclusive use of the read port and is not touched.

---
 rtl/fb_write_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: owns the framebuffer SRAM write port and shares it between
// the pixel renderer (valid/ready) and a built-in clear engine that fills
// locations 0..DEPTH-1 with a single colour.
//
// While a clear runs, a waiting renderer alternates with the clear engine:
// one clear write, then one draw write. With no draw pending, the clear
// advances every cycle. All write outputs are registered (1-cycle latency).
//
// Optional build macro: FB_ARB_STALL_CNT_EN adds o_stall_count, a saturating
// count of cycles in which the renderer was valid but not accepted.
module fb_write_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_draw_valid,
    input  logic [ADDR_WIDTH-1:0] i_draw_addr,
    input  logic [DATA_WIDTH-1:0] i_draw_data,
    output logic                  o_draw_ready,
    input  logic                  i_clear_start,
    input  logic [DATA_WIDTH-1:0] i_clear_colour,
    output logic                  o_clear_busy,
    output logic                  o_clear_done,
    output logic                  o_write,
    output logic [ADDR_WIDTH-1:0] o_write_addr,
    output logic [DATA_WIDTH-1:0] o_data
`ifdef FB_ARB_STALL_CNT_EN
    ,
    output logic [15:0]           o_stall_count
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Address of the final clear write; the grant at this count ends the clear.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Control state
    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clear_cnt;
    logic [ADDR_WIDTH-1:0]   clear_cnt_next;
    logic                    last_was_clear;
    logic                    last_was_clear_next;
    logic [DATA_WIDTH-1:0]   colour;
    logic [DATA_WIDTH-1:0]   colour_next;

    // Arbitration decisions for the current cycle
    logic                    draw_grant;
    logic                    clear_grant;
    logic                    clear_last;
    logic                    start_accept;

    // Write stage (registered towards the SRAM)
    logic                    write_p1;
    logic [ADDR_WIDTH-1:0]   write_addr_p1;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic                    done_p1;
    logic                    write_next;
    logic [ADDR_WIDTH-1:0]   write_addr_next;
    logic [DATA_WIDTH-1:0]   data_next;
    logic                    done_next;

    // Ready depends only on state: always in IDLE, and in CLEAR only after
    // the clear engine has taken the previous slot.
    always_comb begin
        o_draw_ready = 1'b1;
        if (state == CLEAR) begin
            o_draw_ready = last_was_clear;
        end
    end

    // Grant decode: a draw wins the slot when ready; the clear takes any
    // slot in CLEAR that the draw did not use.
    always_comb begin
        draw_grant   = i_draw_valid && o_draw_ready;
        clear_grant  = (state == CLEAR) && !draw_grant;
        clear_last   = clear_grant && (clear_cnt == LAST_ADDR);
        start_accept = (state == IDLE) && i_clear_start;
    end

    // Next-state logic for the clear FSM, sweep counter and fairness flag.
    always_comb begin
        state_next          = state;
        clear_cnt_next      = clear_cnt;
        colour_next         = colour;
        last_was_clear_next = last_was_clear;

        case (state)
            IDLE: begin
                if (start_accept) begin
                    state_next     = CLEAR;
                    clear_cnt_next = '0;
                    colour_next    = i_clear_colour;
                end
            end
            CLEAR: begin
                if (clear_grant) begin
                    if (clear_last) begin
                        state_next     = IDLE;
                        clear_cnt_next = '0;
                    end else begin
                        clear_cnt_next = clear_cnt + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Entering CLEAR hands the first slot to the clear engine.
        if (start_accept) begin
            last_was_clear_next = 1'b0;
        end else if (clear_grant) begin
            last_was_clear_next = 1'b1;
        end else if (draw_grant) begin
            last_was_clear_next = 1'b0;
        end
    end

    // Write-stage mux: draw passes straight through, clear uses counter and
    // latched colour, and an idle slot holds the last address/data.
    always_comb begin
        write_next      = draw_grant || clear_grant;
        write_addr_next = write_addr_p1;
        data_next       = data_p1;
        done_next       = clear_last;

        if (draw_grant) begin
            write_addr_next = i_draw_addr;
            data_next       = i_draw_data;
        end else if (clear_grant) begin
            write_addr_next = clear_cnt;
            data_next       = colour;
        end
    end

    // ---- stage p0 -> p1: control state and registered write port ----
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            clear_cnt      <= '0;
            last_was_clear <= 1'b0;
            write_p1       <= 1'b0;
            write_addr_p1  <= '0;
            data_p1        <= '0;
            done_p1        <= 1'b0;
        end else begin
            state          <= state_next;
            clear_cnt      <= clear_cnt_next;
            last_was_clear <= last_was_clear_next;
            write_p1       <= write_next;
            write_addr_p1  <= write_addr_next;
            data_p1        <= data_next;
            done_p1        <= done_next;
        end
    end

    // Fill colour register; only read while in CLEAR, after it has been loaded.
    always_ff @(posedge i_clk) begin
        colour <= colour_next;
    end

    assign o_clear_busy = (state == CLEAR);
    assign o_clear_done = done_p1;
    assign o_write      = write_p1;
    assign o_write_addr = write_addr_p1;
    assign o_data       = data_p1;

`ifdef FB_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end
        return value + 16'd1;
    endfunction

    // Renderer stall counter: counts valid-but-not-ready cycles, cleared on
    // each accepted clear start.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
        end else if (start_accept) begin
            stall_cnt <= '0;
        end else if (i_draw_valid && !o_draw_ready) begin
            stall_cnt <= sat_inc16(stall_cnt);
        end
    end

    assign o_stall_count = stall_cnt;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed bench for fb_write_arbiter (DEPTH=16) with a
// scoreboard of expected SRAM writes that is popped whenever o_write is high.
module tb_fb_write_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          draw_valid;
    logic [AW-1:0] draw_addr;
    logic [DW-1:0] draw_data;
    logic          draw_ready;
    logic          clear_start;
    logic [DW-1:0] clear_colour;
    logic          clear_busy;
    logic          clear_done;
    logic          write;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] data;
`ifdef FB_ARB_STALL_CNT_EN
    logic [15:0]   stall_count;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_writes = 0;
    logic mon_en  = 1'b0;

    fb_write_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_draw_valid(draw_valid),
        .i_draw_addr(draw_addr),
        .i_draw_data(draw_data),
        .o_draw_ready(draw_ready),
        .i_clear_start(clear_start),
        .i_clear_colour(clear_colour),
        .o_clear_busy(clear_busy),
        .o_clear_done(clear_done),
        .o_write(write),
        .o_write_addr(write_addr),
        .o_data(data)
`ifdef FB_ARB_STALL_CNT_EN
        ,
        .o_stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic dn);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.done = dn;
        exp_q.push_back(e);
    endtask

    task automatic push_clear(input logic [DW-1:0] col);
        for (int i = 0; i < DEPTH; i++) begin
            push(AW'(i), col, (i == DEPTH - 1));
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic st, input logic [DW-1:0] col);
        @(negedge clk);
        draw_valid   = v;
        draw_addr    = a;
        draw_data    = d;
        clear_start  = st;
        clear_colour = col;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 64 && exp_q.size() != 0; c++) begin
            drive(1'b0, '0, '0, 1'b0, '0);
            @(posedge clk);
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        @(posedge clk);
        @(negedge clk);
        chk(tag, exp_q.size(), 0);
    endtask

    // Scoreboard monitor: every write must match the head of the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (write === 1'b1) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_queue", exp_q.size(), 1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", write_addr, e.addr);
                    chk("write_data", data, e.data);
                    chk("write_done", clear_done, e.done);
                end
            end else begin
                chk("write_idle", write, 0);
                chk("done_without_write", clear_done, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int busy_cnt;
        int done_cnt;

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom), DW'($urandom));
            @(posedge clk);
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        rst_n = 1'b1;
        chk("reset_write", write, 0);
        chk("reset_addr", write_addr, 0);
        chk("reset_data", data, 0);
        chk("reset_busy", clear_busy, 0);
        chk("reset_done", clear_done, 0);
        chk("reset_ready", draw_ready, 1);
`ifdef FB_ARB_STALL_CNT_EN
        chk("reset_stall", stall_count, 0);
`endif
        mon_en = 1'b1;

        // Draw passthrough in IDLE
        drive(1'b1, 8'h12, 8'hA5, 1'b0, '0);
        chk("idle_ready", draw_ready, 1);
        push(8'h12, 8'hA5, 1'b0);
        @(posedge clk);
        drive(1'b0, '0, '0, 1'b0, '0);
        chk("ready_after_draw", draw_ready, 1);
        @(posedge clk);
        drain("drain_draw");

        // Clear alone
        drive(1'b0, '0, '0, 1'b1, 8'h3C);
        push_clear(8'h3C);
        @(posedge clk);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 22; i++) begin
            drive(1'b0, '0, '0, 1'b0, '0);
            busy_cnt += int'(clear_busy);
            done_cnt += int'(clear_done);
            @(posedge clk);
        end
        chk("clear_busy_cycles", busy_cnt, 16);
        chk("clear_done_pulses", done_cnt, 1);
        drain("drain_clear");

        // Clear with renderer valid every cycle: strict alternation
        n_writes = 0;
        push(8'h80, 8'h50, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            push(AW'(i), 8'h3C, (i == DEPTH - 1));
            if (i < DEPTH - 1) push(AW'(8'h80 + i + 1), DW'(8'h50 + i + 1), 1'b0);
        end
        push(8'h90, 8'h60, 1'b0);
        k = 0;
        drive(1'b1, 8'h80, 8'h50, 1'b1, 8'h3C);
        if (draw_ready) k++;
        @(posedge clk);
        for (int c = 0; c < 80 && k < 17; c++) begin
            drive(1'b1, AW'(8'h80 + k), DW'(8'h50 + k), 1'b0, '0);
            if (draw_ready) k++;
            @(posedge clk);
        end
        chk("draws_accepted", k, 17);
        drain("drain_interleave");
        chk("interleave_writes", n_writes, 33);
`ifdef FB_ARB_STALL_CNT_EN
        chk("stall_count", stall_count, 16);
`endif

        // Second start during a clear is ignored
        drive(1'b0, '0, '0, 1'b1, 8'h3C);
        push_clear(8'h3C);
        @(posedge clk);
        for (int i = 0; i < 22; i++) begin
            drive(1'b0, '0, '0, (i == 5), 8'hFF);
            @(posedge clk);
        end
        drain("drain_restart_ignored");
        chk("busy_after_ignored", clear_busy, 0);

        // Reset in the middle of a clear, then a fresh clear
        drive(1'b0, '0, '0, 1'b1, 8'h3C);
        for (int i = 0; i < 7; i++) push(AW'(i), 8'h3C, 1'b0);
        @(posedge clk);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, '0, '0, 1'b0, '0);
            @(posedge clk);
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_write", write, 0);
        chk("abort_busy", clear_busy, 0);
        chk("abort_done", clear_done, 0);
        chk("abort_ready", draw_ready, 1);
        chk("abort_queue", exp_q.size(), 0);
        rst_n = 1'b1;
        drive(1'b0, '0, '0, 1'b1, 8'h77);
        push_clear(8'h77);
        @(posedge clk);
        drain("drain_after_abort");
        chk("final_busy", clear_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
